// File: rtl/scrambler_pkg.sv
// rtl/scrambler_pkg.sv - shared state type, default taps and permutation index helper
package scrambler_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      EXHAUST
   } state_t;

   // x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

   // Source bit that feeds load bit i. The multiplier 2*sel+1 is odd, so for a
   // power-of-two width every i maps to a distinct source bit.
   function automatic int perm_idx(input int i, input int sel, input int state_w);
      return (i * (2 * sel + 1) + sel) % state_w;
   endfunction

endpackage

// File: rtl/scrambler_perm.sv
// rtl/scrambler_perm.sv - selectable bijective bit permutation building the seed
module scrambler_perm
   import scrambler_pkg::*;
#(
   parameter int STATE_W = 32,
   parameter int SEL_W   = 5
) (
   input  logic [STATE_W-1:0] src,
   input  logic [SEL_W-1:0]   sel,
   output logic [STATE_W-1:0] load
);

   localparam int IDX_W = $clog2(STATE_W);

   for (genvar i = 0; i < STATE_W; i++) begin : g_bit
      logic [IDX_W-1:0] idx;
      assign idx     = IDX_W'(perm_idx(i, int'(sel), STATE_W));
      assign load[i] = src[idx];
   end

endmodule

// File: rtl/scrambler_seed_engine.sv
// rtl/scrambler_seed_engine.sv - seeded LFSR keystream scrambler with rekey limit
module scrambler_seed_engine
   import scrambler_pkg::*;
#(
   parameter int                 STATE_W     = 32,
   parameter int                 DATA_W      = 8,
   parameter int                 SEL_W       = 5,
   parameter logic [STATE_W-1:0] TAPS        = STATE_W'(DEFAULT_TAPS),
   parameter int                 REKEY_BEATS = 1024,
   parameter int                 CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      seed_req,
   input  logic [DATA_W-1:0]         seed_data,
   input  logic [STATE_W-DATA_W-1:0] seed_entropy,
   input  logic [SEL_W-1:0]          seed_sel,
   output logic                      seed_busy,
   input  logic                      in_valid,
   input  logic [DATA_W-1:0]         in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   input  logic                      out_ready,
   output logic [CNT_W-1:0]          beat_cnt,
   output logic                      rekey_needed
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REKEY_BEATS);

   state_t                    state;
   logic [STATE_W-1:0]        lfsr;
   logic [DATA_W-1:0]         data_q;
   logic [STATE_W-DATA_W-1:0] entropy_q;
   logic [SEL_W-1:0]          sel_q;

   logic [STATE_W-1:0]        src;
   logic [STATE_W-1:0]        load;
   logic [STATE_W-1:0]        ks_state;
   logic [DATA_W-1:0]         ks;
   logic [CNT_W-1:0]          cnt_inc;
   logic                      start_seed;
   logic                      accept;

   // A reseed is taken in every state except LOAD and always beats a data beat
   assign start_seed = seed_req && (state != LOAD);
   assign in_ready   = (state == RUN) && !seed_req && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign cnt_inc    = beat_cnt + CNT_W'(1);
   assign src        = {entropy_q, data_q};

   scrambler_perm #(
      .STATE_W (STATE_W),
      .SEL_W   (SEL_W)
   ) u_perm (
      .src  (src),
      .sel  (sel_q),
      .load (load)
   );

   // Keystream bit k is the LFSR MSB after k steps; ks_state ends DATA_W steps ahead
   always_comb begin
      ks       = '0;
      ks_state = lfsr;
      for (int k = 0; k < DATA_W; k++) begin
         ks[k]    = ks_state[STATE_W-1];
         ks_state = {ks_state[STATE_W-2:0], ^(ks_state & TAPS)};
      end
   end

   // Seed/run state machine, beat counter and registered output beat
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         lfsr         <= '0;
         data_q       <= '0;
         entropy_q    <= '0;
         sel_q        <= '0;
         seed_busy    <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         beat_cnt     <= '0;
         rekey_needed <= 1'b0;
      end else begin
         seed_busy <= start_seed;
         if (start_seed) begin
            data_q    <= seed_data;
            entropy_q <= seed_entropy;
            sel_q     <= seed_sel;
         end

         case (state)
            IDLE, EXHAUST: begin
               if (start_seed) state <= LOAD;
            end
            LOAD: begin
               // An all-zero LFSR would lock up, so force a single set bit
               lfsr         <= (load == '0) ? STATE_W'(1) : load;
               beat_cnt     <= '0;
               rekey_needed <= 1'b0;
               state        <= RUN;
            end
            RUN: begin
               if (start_seed) begin
                  state <= LOAD;
               end else if (accept) begin
                  lfsr     <= ks_state;
                  beat_cnt <= cnt_inc;
                  if (cnt_inc == LIMIT) begin
                     state        <= EXHAUST;
                     rekey_needed <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ ks;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scrambler_seed_engine.sv
// tb/tb_scrambler_seed_engine.sv - scoreboard bench for scrambler_seed_engine
module tb_scrambler_seed_engine;

   localparam int          REKEY = 6;
   localparam logic [31:0] TAPS  = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_req;
   logic [7:0]  seed_data;
   logic [23:0] seed_entropy;
   logic [4:0]  seed_sel;
   logic        seed_busy;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic [15:0] beat_cnt;
   logic        rekey_needed;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] m_lfsr;

   scrambler_seed_engine #(
      .STATE_W     (32),
      .DATA_W      (8),
      .SEL_W       (5),
      .REKEY_BEATS (REKEY),
      .CNT_W       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .seed_req     (seed_req),
      .seed_data    (seed_data),
      .seed_entropy (seed_entropy),
      .seed_sel     (seed_sel),
      .seed_busy    (seed_busy),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .beat_cnt     (beat_cnt),
      .rekey_needed (rekey_needed)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] s, input int sel);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i] = s[(i * (2 * sel + 1) + sel) % 32];
      return (r == 32'h0) ? 32'h1 : r;
   endfunction

   task automatic model_step(output logic [7:0] ks);
      ks = '0;
      for (int k = 0; k < 8; k++) begin
         ks[k]  = m_lfsr[31];
         m_lfsr = {m_lfsr[30:0], ^(m_lfsr & TAPS)};
      end
   endtask

   // Monitor: every completed output handshake pops one expected beat
   always begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none", out_data);
         end else begin
            check("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic do_seed(input logic [7:0] d, input logic [23:0] e, input logic [4:0] s);
      m_lfsr = model_load({e, d}, int'(s));
      @(negedge clk);
      seed_req = 1'b1; seed_data = d; seed_entropy = e; seed_sel = s;
      @(negedge clk);
      seed_req = 1'b0;
      #1;
      check("seed_busy_load", seed_busy, 1);
      check("in_ready_load", in_ready, 0);
      @(negedge clk);
      #1;
      check("seed_busy_run", seed_busy, 0);
      check("beat_cnt_after_seed", beat_cnt, 0);
      check("rekey_after_seed", rekey_needed, 0);
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d;
      #1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("send_accept", in_ready, 1);
      if (in_ready) exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_h(input logic [7:0] d, input logic [7:0] e);
      logic [7:0] ks;
      model_step(ks);
      send(d, e);
   endtask

   task automatic send_m(input logic [7:0] d);
      logic [7:0] ks;
      model_step(ks);
      send(d, d ^ ks);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; seed_req = 1'b0; seed_data = '0; seed_entropy = '0; seed_sel = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_beat_cnt", beat_cnt, 0);
      check("rst_rekey", rekey_needed, 0);
      check("rst_seed_busy", seed_busy, 0);
      check("rst_in_ready", in_ready, 0);

      // All-zero seed falls back to lfsr=1, first keystream byte is zero
      do_seed(8'h00, 24'h0, 5'd0);
      send_h(8'hA5, 8'hA5);

      // lfsr=32'h1234565A: first four bytes are the bit-reversed seed bytes
      do_seed(8'h5A, 24'h123456, 5'd0);
      send_h(8'h00, 8'h48);
      #1;
      check("beat_cnt_one", beat_cnt, 1);
      send_h(8'h00, 8'h2C);
      send_h(8'h00, 8'h6A);
      send_h(8'h00, 8'h5A);
      send_m(8'h3C);
      send_m(8'hC3);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'hEE;
      #1;
      check("exhaust_rekey", rekey_needed, 1);
      check("exhaust_in_ready", in_ready, 0);
      check("exhaust_beat_cnt", beat_cnt, REKEY);
      in_valid = 1'b0;
      do_seed(8'h00, 24'h0, 5'd0);

      // Backpressure: held beat stays put, then full-rate burst
      do_seed(8'hFF, 24'h0, 5'd0);
      out_ready = 1'b0;
      send_h(8'h11, 8'h11);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'h22;
         #1;
         check("stall_in_ready", in_ready, 0);
         check("stall_out_valid", out_valid, 1);
         check("stall_out_data", out_data, 8'h11);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("burst_ready_0", in_ready, 1);
      exp_q.push_back(8'h22);
      @(negedge clk);
      in_data = 8'h33;
      #1;
      check("burst_ready_1", in_ready, 1);
      exp_q.push_back(8'h33);
      @(negedge clk);
      in_data = 8'h44;
      #1;
      check("burst_ready_2", in_ready, 1);
      exp_q.push_back(8'hBB);
      @(negedge clk);
      in_valid = 1'b0;

      // Seed request collides with a beat, then reset lands in LOAD
      @(negedge clk);
      seed_req = 1'b1; seed_data = 8'h5A; seed_entropy = 24'h123456; seed_sel = 5'd0;
      in_valid = 1'b1; in_data = 8'h77;
      #1;
      check("collision_in_ready", in_ready, 0);
      @(negedge clk);
      seed_req = 1'b0; in_valid = 1'b0; rst = 1'b1;
      #1;
      check("collision_seed_busy", seed_busy, 1);
      check("collision_beat_cnt", beat_cnt, 4);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_out_data", out_data, 0);
      check("midrst_beat_cnt", beat_cnt, 0);
      check("midrst_rekey", rekey_needed, 0);
      check("midrst_seed_busy", seed_busy, 0);
      check("midrst_in_ready", in_ready, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("idle_seed_busy", seed_busy, 0);

      // Every permutation select against the model, five beats each
      for (int s = 0; s < 32; s++) begin
         do_seed(8'($urandom), 24'($urandom), 5'(s));
         for (int b = 0; b < 5; b++) send_m(8'($urandom));
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
